seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the code-to-segment encoder.
- Passively monitors the multiplexed 7-segment bus (active-low anodes plus active-low segments) driven by the rolling-display path.
- Decodes each stable digit pattern back to its 5-bit code and assembles complete display frames.
- Used for on-board loopback self-check and for capturing the current message content.

---
 rtl/seg_scan_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: passive monitor of a multiplexed 7-segment bus.
// It decodes each stable digit pattern back to its 5-bit code and
// assembles complete display frames.
// Optional build macro: ROLL_DETECT_EN adds the roll_left output.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | anodes not one-hot-low; counter cleared
// SETTLE | one digit selected; counting identical {an,seg} cycles
// HOLD   | digit captured; waiting for {an,seg} to change
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [6:0]              seg,
   output logic [NUM_DIGITS*5-1:0] frame_codes,
   output logic                    frame_valid,
   output logic                    frame_changed,
   output logic                    decode_err
`ifdef ROLL_DETECT_EN
   ,
   output logic                    roll_left
`endif
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SW = NUM_DIGITS + 7;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t                  state, state_nxt;
   logic [SW-1:0]           prev;
   logic [7:0]              cnt, cnt_nxt;
   logic [NUM_DIGITS*5-1:0] shadow, shadow_nxt;
   logic [NUM_DIGITS-1:0]   seen, seen_nxt;
   logic [IW-1:0]           idx;
   logic [4:0]              code;
   logic                    code_err;
   logic                    changed, onehot, capture, frame_done, frame_diff;

   assign changed    = ({an, seg} != prev);
   assign onehot     = $onehot(~an);
   assign frame_done = &seen;
   assign frame_diff = (shadow != frame_codes);

   // Run length of the current pattern, counting this cycle as one.
   always_comb begin
      cnt_nxt = cnt;
      if (!onehot)
         cnt_nxt = 8'd0;
      else if (changed)
         cnt_nxt = 8'd1;
      else if (cnt != STABLE)
         cnt_nxt = cnt + 8'd1;
   end

   // Next state and capture strobe; HOLD persists only while the bus is unchanged.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      if (!onehot)
         state_nxt = IDLE;
      else if (state == HOLD && !changed)
         state_nxt = HOLD;
      else if (cnt_nxt == STABLE) begin
         capture   = 1'b1;
         state_nxt = HOLD;
      end else
         state_nxt = SETTLE;
   end

   // Selected digit index from the single low anode.
   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (!an[i]) idx = IW'(i);
   end

   // Segment-to-code table; aliased patterns appear once, at their lowest code.
   always_comb begin
      code_err = 1'b0;
      case (seg)
         7'b1111111: code = 5'd0;
         7'b0001001: code = 5'd1;
         7'b0000110: code = 5'd2;
         7'b1000111: code = 5'd3;
         7'b1000000: code = 5'd4;
         7'b1111001: code = 5'd5;
         7'b0001000: code = 5'd6;
         7'b1111000: code = 5'd7;
         7'b0000000: code = 5'd8;
         7'b0010000: code = 5'd9;
         7'b0000011: code = 5'd11;
         7'b0100111: code = 5'd12;
         7'b0100001: code = 5'd13;
         7'b0001110: code = 5'd15;
         7'b0100011: code = 5'd16;
         default: begin
            code     = 5'd31;
            code_err = 1'b1;
         end
      endcase
   end

   // Completing frame empties the shadow set before a same-cycle capture lands in it.
   always_comb begin
      shadow_nxt = shadow;
      seen_nxt   = seen;
      if (frame_done) begin
         shadow_nxt = '0;
         seen_nxt   = '0;
      end
      if (capture) begin
         shadow_nxt[idx*5 +: 5] = code;
         seen_nxt[idx]          = 1'b1;
      end
   end

`ifdef ROLL_DETECT_EN
   logic roll_match;

   // New frame is the old one shifted up by one digit.
   always_comb begin
      roll_match = 1'b1;
      for (int i = 1; i < NUM_DIGITS; i++)
         if (shadow[i*5 +: 5] != frame_codes[(i-1)*5 +: 5]) roll_match = 1'b0;
   end
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Sample history, stability counter, shadow frame and output frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev          <= '1;
         cnt           <= 8'd0;
         shadow        <= '0;
         seen          <= '0;
         frame_codes   <= '0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         decode_err    <= 1'b0;
`ifdef ROLL_DETECT_EN
         roll_left     <= 1'b0;
`endif
      end else begin
         prev          <= {an, seg};
         cnt           <= cnt_nxt;
         shadow        <= shadow_nxt;
         seen          <= seen_nxt;
         frame_valid   <= frame_done;
         frame_changed <= frame_done && frame_diff;
         decode_err    <= capture && code_err;
         if (frame_done)
            frame_codes <= shadow;
`ifdef ROLL_DETECT_EN
         roll_left     <= frame_done && frame_diff && roll_match;
`endif
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg_scan_decoder;

   localparam logic [6:0] S1   = 7'b0001001;
   localparam logic [6:0] S2   = 7'b0000110;
   localparam logic [6:0] S3   = 7'b1000111;
   localparam logic [6:0] S4   = 7'b1000000;
   localparam logic [6:0] S5   = 7'b1111001;
   localparam logic [6:0] S8   = 7'b0000000;
   localparam logic [6:0] SBAD = 7'b0101010;

   typedef struct {
      logic [6:0] seg;
      logic [4:0] code;
      logic       err;
   } vec_t;

   typedef struct {
      logic [19:0] frame;
      logic        changed;
      logic        roll;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [19:0] frame_codes;
   logic        frame_valid, frame_changed, decode_err;
`ifdef ROLL_DETECT_EN
   logic        roll_left;
`endif

   vec_t        vt[16];
   exp_t        sb[$];
   logic [19:0] model_last;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          err_seen = 0;
   int          err_exp  = 0;

   seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .an            (an),
      .seg           (seg),
      .frame_codes   (frame_codes),
      .frame_valid   (frame_valid),
      .frame_changed (frame_changed),
      .decode_err    (decode_err)
`ifdef ROLL_DETECT_EN
      ,
      .roll_left     (roll_left)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] anl(input int d);
      logic [3:0] v;
      v = 4'b1111;
      v[d] = 1'b0;
      return v;
   endfunction

   function automatic logic [19:0] mk(input logic [4:0] c3, input logic [4:0] c2,
                                      input logic [4:0] c1, input logic [4:0] c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic expect_frame(input logic [19:0] f);
      exp_t e;
      e.frame   = f;
      e.changed = (f != model_last);
      e.roll    = e.changed && (f[9:5] == model_last[4:0]) &&
                  (f[14:10] == model_last[9:5]) && (f[19:15] == model_last[14:10]);
      sb.push_back(e);
      model_last = f;
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan_tab(input int f, input int dwell);
      expect_frame(mk(vt[4*f+3].code, vt[4*f+2].code, vt[4*f+1].code, vt[4*f].code));
      for (int d = 0; d < 4; d++) begin
         if (vt[4*f+d].err) err_exp++;
         drive(anl(d), vt[4*f+d].seg, dwell);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      an  = 4'b1111;
      seg = 7'b1111111;
      @(negedge clk);
      chk("rst_frame_codes",   32'(frame_codes),   32'd0);
      chk("rst_frame_valid",   32'(frame_valid),   32'd0);
      chk("rst_frame_changed", 32'(frame_changed), 32'd0);
      chk("rst_decode_err",    32'(decode_err),    32'd0);
      rst = 1'b0;
      model_last = '0;
   endtask

   // Scoreboard consumer: every frame_valid pops one expected frame.
   always @(negedge clk) begin
      if (!rst && decode_err) err_seen++;
      if (!rst && frame_valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame: got frame %0h expected no frame", frame_codes);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("frame_codes",   32'(frame_codes),   32'(e.frame));
            chk("frame_changed", 32'(frame_changed), 32'(e.changed));
`ifdef ROLL_DETECT_EN
            chk("roll_left",     32'(roll_left),     32'(e.roll));
`endif
         end
      end
   end

   initial begin
      vt[0]  = '{S1, 5'd1, 1'b0};
      vt[1]  = '{S2, 5'd2, 1'b0};
      vt[2]  = '{S3, 5'd3, 1'b0};
      vt[3]  = '{S4, 5'd4, 1'b0};
      vt[4]  = '{7'b1111111, 5'd0, 1'b0};
      vt[5]  = '{S5, 5'd5, 1'b0};
      vt[6]  = '{7'b0001000, 5'd6, 1'b0};
      vt[7]  = '{7'b1111000, 5'd7, 1'b0};
      vt[8]  = '{S8, 5'd8, 1'b0};
      vt[9]  = '{7'b0010000, 5'd9, 1'b0};
      vt[10] = '{7'b0000011, 5'd11, 1'b0};
      vt[11] = '{7'b0100111, 5'd12, 1'b0};
      vt[12] = '{7'b0100001, 5'd13, 1'b0};
      vt[13] = '{7'b0001110, 5'd15, 1'b0};
      vt[14] = '{SBAD, 5'd31, 1'b1};
      vt[15] = '{7'b0100011, 5'd16, 1'b0};
      model_last = '0;

      rst = 1'b1;
      an  = 4'b1111;
      seg = 7'b1111111;
      repeat (2) @(negedge clk);
      do_reset();

      // Table frames: first one twice (unchanged repeat), then minimum dwell.
      scan_tab(0, 6);
      scan_tab(0, 6);
      scan_tab(1, 4);
      scan_tab(2, 6);
      scan_tab(3, 6);
      chk("err_after_table", 32'(err_seen), 32'(err_exp));

      // Digit 2 dwell too short: frame only after it is rescanned.
      drive(anl(0), S1, 6);
      drive(anl(1), S2, 6);
      drive(anl(2), S5, 3);
      drive(anl(3), S4, 6);
      expect_frame(mk(5'd4, 5'd3, 5'd2, 5'd1));
      drive(anl(2), S3, 6);

      // Two anodes low, then none: no capture, outputs held.
      drive(4'b1100, S8, 10);
      drive(4'b1111, S8, 5);
      chk("held_frame_codes", 32'(frame_codes), 32'(model_last));
      drive(anl(2), S3, 6);
      drive(anl(3), S4, 6);
      expect_frame(mk(5'd4, 5'd3, 5'd2, 5'd1));
      drive(anl(0), S1, 6);
      drive(anl(1), S2, 6);

      // Segment glitch while holding digit 0 re-captures it; frame rolls left.
      expect_frame(mk(5'd3, 5'd2, 5'd1, 5'd5));
      drive(anl(0), S1, 5);
      drive(anl(0), S5, 5);
      drive(anl(1), S1, 6);
      drive(anl(2), S2, 6);
      drive(anl(3), S3, 6);

      // Long dwell on a bad pattern captures (and flags) once.
      expect_frame(mk(5'd4, 5'd4, 5'd31, 5'd4));
      err_exp++;
      drive(anl(0), S4, 6);
      drive(anl(1), SBAD, 20);
      drive(anl(2), S4, 6);
      drive(anl(3), S4, 6);
      drive(4'b1111, S8, 3);
      chk("err_long_hold", 32'(err_seen), 32'(err_exp));

      // Reset after three captures discards the partial frame.
      drive(anl(0), S1, 6);
      drive(anl(1), S2, 6);
      drive(anl(2), S3, 6);
      do_reset();
      drive(anl(3), S4, 6);
      expect_frame(mk(5'd4, 5'd5, 5'd5, 5'd5));
      drive(anl(0), S5, 6);
      drive(anl(1), S5, 6);
      drive(anl(2), S5, 6);
      drive(4'b1111, S8, 6);

      chk("frames_pending", 32'(sb.size()), 32'd0);
      chk("err_total", 32'(err_seen), 32'(err_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
